// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline: datapath widths, ALU command
// encodings and the control-bit bundle carried from ID into EXE.
package arm_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 4;

    // ALU command encodings; EXE_NOP is what a squashed slot carries
    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    // Control bits that must all be clear whenever the slot is not valid
    typedef struct packed {
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
        logic b;
        logic s;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Gate the control bundle with the valid bit so a dead slot never writes
    function automatic ctrl_t ctrl_gate(input logic valid, input ctrl_t ctrl);
        return valid ? ctrl : CTRL_NOP;
    endfunction

endpackage

// File: rtl/id_exe_stage_reg_if.sv
// ID->EXE bus: decoded fields presented by ID and their registered copies
// seen by EXE, forwarding and hazard logic.
interface id_exe_stage_reg_if;
    import arm_pkg::*;

    logic              id_valid;
    logic [WORD_W-1:0] id_pc;
    logic [WORD_W-1:0] id_val_rn;
    logic [WORD_W-1:0] id_val_rm;
    logic [REG_W-1:0]  id_src1;
    logic [REG_W-1:0]  id_src2;
    logic [REG_W-1:0]  id_dest;
    logic [3:0]        id_exe_cmd;
    logic              id_mem_r_en;
    logic              id_mem_w_en;
    logic              id_wb_en;
    logic              id_b;
    logic              id_s;
    logic              id_imm;
    logic [11:0]       id_shift_operand;
    logic [23:0]       id_signed_imm_24;
    logic              id_carry;

    logic              exe_valid;
    logic [WORD_W-1:0] exe_pc;
    logic [WORD_W-1:0] exe_val_rn;
    logic [WORD_W-1:0] exe_val_rm;
    logic [REG_W-1:0]  exe_src1;
    logic [REG_W-1:0]  exe_src2;
    logic [REG_W-1:0]  exe_dest;
    logic [3:0]        exe_exe_cmd;
    logic              exe_mem_r_en;
    logic              exe_mem_w_en;
    logic              exe_wb_en;
    logic              exe_b;
    logic              exe_s;
    logic              exe_imm;
    logic [11:0]       exe_shift_operand;
    logic [23:0]       exe_signed_imm_24;
    logic              exe_carry;

    // Pipeline side: drives ID fields, observes EXE fields
    modport master (
        output id_valid, id_pc, id_val_rn, id_val_rm, id_src1, id_src2, id_dest,
               id_exe_cmd, id_mem_r_en, id_mem_w_en, id_wb_en, id_b, id_s,
               id_imm, id_shift_operand, id_signed_imm_24, id_carry,
        input  exe_valid, exe_pc, exe_val_rn, exe_val_rm, exe_src1, exe_src2,
               exe_dest, exe_exe_cmd, exe_mem_r_en, exe_mem_w_en, exe_wb_en,
               exe_b, exe_s, exe_imm, exe_shift_operand, exe_signed_imm_24,
               exe_carry
    );

    // Stage register side: samples ID fields, drives EXE fields
    modport slave (
        input  id_valid, id_pc, id_val_rn, id_val_rm, id_src1, id_src2, id_dest,
               id_exe_cmd, id_mem_r_en, id_mem_w_en, id_wb_en, id_b, id_s,
               id_imm, id_shift_operand, id_signed_imm_24, id_carry,
        output exe_valid, exe_pc, exe_val_rn, exe_val_rm, exe_src1, exe_src2,
               exe_dest, exe_exe_cmd, exe_mem_r_en, exe_mem_w_en, exe_wb_en,
               exe_b, exe_s, exe_imm, exe_shift_operand, exe_signed_imm_24,
               exe_carry
    );

endinterface

// File: rtl/id_exe_stage_reg_sat_counter.sv
// Generic up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Increment when enabled unless already saturated
    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + ONE;
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with freeze (hold), flush/bubble (NOP insert)
// and a saturating count of inserted NOPs.
module id_exe_stage_reg
    import arm_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     freeze,
    input  logic                     flush,
    input  logic                     bubble,
    id_exe_stage_reg_if.slave        bus,
    output logic [15:0]              bubble_count
);

    ctrl_t id_ctrl;
    logic  nop_load;

    logic              valid_q,  valid_d;
    ctrl_t             ctrl_q,   ctrl_d;
    logic [3:0]        cmd_q,    cmd_d;
    logic [REG_W-1:0]  dest_q,   dest_d;
    logic [REG_W-1:0]  src1_q,   src1_d;
    logic [REG_W-1:0]  src2_q,   src2_d;
    logic [WORD_W-1:0] pc_q,     pc_d;
    logic [WORD_W-1:0] val_rn_q, val_rn_d;
    logic [WORD_W-1:0] val_rm_q, val_rm_d;
    logic              imm_q,    imm_d;
    logic [11:0]       shop_q,   shop_d;
    logic [23:0]       simm_q,   simm_d;
    logic              carry_q,  carry_d;

    assign id_ctrl  = {bus.id_wb_en, bus.id_mem_r_en, bus.id_mem_w_en, bus.id_b, bus.id_s};
    assign nop_load = !freeze && (flush || bubble);

    // Next state: freeze holds everything; NOP loads clear the control side
    // but still take the datapath fields so their contents stay deterministic
    always_comb begin
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        cmd_d    = cmd_q;
        dest_d   = dest_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        pc_d     = pc_q;
        val_rn_d = val_rn_q;
        val_rm_d = val_rm_q;
        imm_d    = imm_q;
        shop_d   = shop_q;
        simm_d   = simm_q;
        carry_d  = carry_q;
        if (!freeze) begin
            pc_d     = bus.id_pc;
            val_rn_d = bus.id_val_rn;
            val_rm_d = bus.id_val_rm;
            imm_d    = bus.id_imm;
            shop_d   = bus.id_shift_operand;
            simm_d   = bus.id_signed_imm_24;
            carry_d  = bus.id_carry;
            if (flush || bubble) begin
                valid_d = 1'b0;
                ctrl_d  = CTRL_NOP;
                cmd_d   = EXE_NOP;
                dest_d  = '0;
                src1_d  = '0;
                src2_d  = '0;
            end else begin
                valid_d = bus.id_valid;
                ctrl_d  = ctrl_gate(bus.id_valid, id_ctrl);
                cmd_d   = bus.id_exe_cmd;
                dest_d  = bus.id_dest;
                src1_d  = bus.id_src1;
                src2_d  = bus.id_src2;
            end
        end
    end

    // Stage registers, cleared asynchronously (reset overrides freeze)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            ctrl_q   <= CTRL_NOP;
            cmd_q    <= EXE_NOP;
            dest_q   <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            pc_q     <= '0;
            val_rn_q <= '0;
            val_rm_q <= '0;
            imm_q    <= 1'b0;
            shop_q   <= '0;
            simm_q   <= '0;
            carry_q  <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            cmd_q    <= cmd_d;
            dest_q   <= dest_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            pc_q     <= pc_d;
            val_rn_q <= val_rn_d;
            val_rm_q <= val_rm_d;
            imm_q    <= imm_d;
            shop_q   <= shop_d;
            simm_q   <= simm_d;
            carry_q  <= carry_d;
        end
    end

    sat_counter #(.WIDTH(16)) u_bubble_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .en_i    (nop_load),
        .count_o (bubble_count)
    );

    assign bus.exe_valid         = valid_q;
    assign bus.exe_wb_en         = ctrl_q.wb_en;
    assign bus.exe_mem_r_en      = ctrl_q.mem_r_en;
    assign bus.exe_mem_w_en      = ctrl_q.mem_w_en;
    assign bus.exe_b             = ctrl_q.b;
    assign bus.exe_s             = ctrl_q.s;
    assign bus.exe_exe_cmd       = cmd_q;
    assign bus.exe_dest          = dest_q;
    assign bus.exe_src1          = src1_q;
    assign bus.exe_src2          = src2_q;
    assign bus.exe_pc            = pc_q;
    assign bus.exe_val_rn        = val_rn_q;
    assign bus.exe_val_rm        = val_rm_q;
    assign bus.exe_imm           = imm_q;
    assign bus.exe_shift_operand = shop_q;
    assign bus.exe_signed_imm_24 = simm_q;
    assign bus.exe_carry         = carry_q;

endmodule

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
- Pipeline register between the ID and EXE stages of the 5-stage ARM core.
- Captures decoded control, operand values and register addresses from ID every cycle.
- Presents them to the EXE stage. src1/src2 outputs feed the forwarding unit; dest/wb_en feed hazard detection.
- Supports freeze (memory stall hold), flush (taken branch) and bubble insertion (hazard NOP).

Parameters:
- WORD_W, 32, width of PC and operand datapaths
- REG_W, 4, register-file address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- freeze  in  1  hold all contents (SRAM/cache stall)
- flush  in  1  taken branch from EXE; squash the incoming ID instruction
- bubble  in  1  hazard stall; load a NOP instead of the ID instruction
- id_valid  in  1  ID stage holds a real instruction
- id_pc  in  WORD_W  PC+4 of the ID instruction
- id_val_rn, id_val_rm  in  WORD_W  register-file read data
- id_src1, id_src2  in  REG_W  source register numbers
- id_dest  in  REG_W  destination register
- id_exe_cmd  in  4  ALU command
- id_mem_r_en, id_mem_w_en, id_wb_en, id_b, id_s  in  1  control bits
- id_imm  in  1  immediate-operand flag
- id_shift_operand  in  12  shifter operand field
- id_signed_imm_24  in  24  branch offset
- id_carry  in  1  status-register C flag sampled in ID
- exe_* outputs  out  same widths as the id_* inputs above; registered copies, including exe_valid
- bubble_count  out  16  saturating count of NOPs inserted by bubble or flush (performance counter)

Behaviour:
- Reset (rst=0, asynchronous): every exe_* output is 0 and bubble_count is 0. Release is synchronous to the next clk edge.
- Each clk rising edge is evaluated in priority order freeze > flush > bubble > load.
- freeze=1:
  - All registers, including bubble_count, hold.
  - flush and bubble are ignored that cycle. The upstream stages are frozen too, so they re-present the same inputs.
- flush=1 (freeze=0): the NOP load applies.
  - Cleared: exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s.
  - exe_exe_cmd=0, exe_dest=0, exe_src1=0, exe_src2=0.
  - Datapath fields are loaded from the id_* inputs normally; they are don't-care but deterministic.
  - bubble_count increments.
- bubble=1 (freeze=0, flush=0): the same NOP load as flush.
- Otherwise: all exe_* outputs take their id_* values. exe_valid=id_valid.
  - If id_valid=0, the control bits are forced clear, as in a NOP.
  - bubble_count is unchanged.
- NOP invariant: whenever exe_valid=0, the registered wb_en, mem_r_en, mem_w_en, b and s bits are 0. This prevents false forwarding or writes.
- src1/src2 being 0 on a NOP is harmless: wb_en=0 downstream blocks any forwarding match.
- Latency: exactly 1 cycle from id_* to exe_*; no combinational path from input to output.
- bubble_count saturates at 16'hFFFF and does not wrap.
- Simultaneous flush and bubble: flush wins; the count increments once.
- Reset asserted mid-freeze: the reset clears immediately and overrides the freeze.

Decomposition:
- Shared package (arm_pkg) holds:
  - WORD_W and REG_W
  - the exe_cmd encodings, including EXE_NOP=4'b0000
  - a control-bundle type {wb_en, mem_r_en, mem_w_en, b, s}
- One natural sub-module: sat_counter (a generic WIDTH-bit saturating up-counter with enable and async active-low reset), used for bubble_count.

Test Plan:
- Reset: drive rst=0 mid-cycle with random inputs -> all exe_* outputs and bubble_count are 0 immediately; after release, the first edge loads id_*.
- Normal load: id_dest=4'd5, id_wb_en=1, id_val_rn=32'h1234_5678, id_valid=1 -> one edge later exe_dest=5, exe_wb_en=1, exe_val_rn=32'h1234_5678, exe_valid=1.
- Freeze: load an instruction, then hold freeze=1 for 3 cycles with changing id_* and flush=1 -> exe_* are unchanged and bubble_count stays 0; after freeze drops, the next edge takes the new inputs.
- Flush vs bubble: flush=1 and bubble=1 with id_wb_en=1, id_mem_w_en=1 -> exe_valid=0, exe_wb_en=0, exe_mem_w_en=0, exe_exe_cmd=0, bubble_count=1.
- Invalid ID: id_valid=0, id_wb_en=1, id_b=1 -> exe_wb_en=0, exe_b=0, bubble_count unchanged.
- Saturation: preload via 65535 bubble cycles, then 2 more -> bubble_count holds 16'hFFFF.
